// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute
// plus combinational immediate-format and ALU-operation decode.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       instr_done
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       op_legal;
  logic       branch_taken;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_BR) || (op == OP_JAL);
  end

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = Zero;
      3'b001:  branch_taken = ~Zero;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b01;
        instr_done = ~op_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        alu_op     = 2'b01;
        PCWrite    = branch_taken;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // ALUOp 11 is never produced; it decodes like 10.
  always_comb begin
    case (alu_op)
      2'b00: ALUControl = 4'b0000;
      2'b01: ALUControl = 4'b0001;
      default: begin
        case (funct3)
          3'b000:        ALUControl = (funct7b5 & op[5]) ? 4'b0001 : 4'b0000;
          3'b001:        ALUControl = 4'b0100;
          3'b010, 3'b011: ALUControl = 4'b0101;
          3'b100:        ALUControl = 4'b0110;
          3'b101:        ALUControl = funct7b5 ? 4'b1000 : 4'b0111;
          3'b110:        ALUControl = 4'b0011;
          default:       ALUControl = 4'b0010;
        endcase
      end
    endcase
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have these ports:
  clk  input  1  single system clock; all state updates on the rising edge.
  reset  input  1  synchronous, active-high reset, sampled on the rising clk edge.
  op  input  7  opcode field of the instruction register.
  funct3  input  3  funct3 field of the instruction register.
  funct7b5  input  1  instruction bit 30.
  Zero  input  1  ALU zero flag.
  PCWrite  output  1  PC register enable.
  AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut.
  MemWrite  output  1  data memory write strobe.
  IRWrite  output  1  instruction/OldPC register enable.
  RegWrite  output  1  register file write enable.
  ResultSrc  output  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult.
  ALUSrcA  output  2  ALU A mux: 00=PC, 01=OldPC, 10=rs1.
  ALUSrcB  output  2  ALU B mux: 00=rs2, 01=ImmExt, 10=constant 4.
  ImmSrc  output  2  immediate format: 00=I, 01=S, 10=B, 11=J.
  ALUControl  output  4  ALU operation code.
  instr_done  output  1  one-cycle pulse on the final cycle of each instruction.

Function
REQ-002 Supported opcodes: 0000011 lw, 0100011 sw, 0110011 R-type, 0010011 I-type ALU, 1100011 branch, 1101111 jal.
REQ-003 The block SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL.
REQ-004 Transitions: FETCH->DECODE; DECODE->MEMADR (lw/sw), EXECUTER (R), EXECUTEI (I-ALU), BRANCH (branch), JAL (jal), FETCH (any other opcode).
REQ-005 Further transitions: MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB; EXECUTER/EXECUTEI/JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
REQ-006 Instruction latency: lw 5 cycles; R, I, jal 4 cycles; sw 4 cycles; branch 3 cycles; illegal opcode 2 cycles with no memory write, register write or PC write in DECODE.
REQ-007 Per-state outputs (all outputs not listed are 0):
  FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1.
  DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  MEMREAD: ResultSrc=00, AdrSrc=1.
  MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  MEMWB: ResultSrc=01, RegWrite=1.
  EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  ALUWB: ResultSrc=00, RegWrite=1.
  JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=taken.
REQ-008 Branch taken SHALL be Zero when funct3=000 (beq), ~Zero when funct3=001 (bne), and 0 for all other funct3 values.
REQ-009 ImmSrc SHALL be decoded combinationally from op: lw/I-ALU 00, sw 01, branch 10, jal 11, other 00.
REQ-010 ALUOp is an internal 2-bit signal: 00 gives ALUControl=0000 (add); 01 gives 0001 (sub).
REQ-011 ALUOp=10 gives ALUControl by funct3: 000 gives 0001 if funct7b5&op[5] else 0000; 001 gives 0100; 010 and 011 give 0101; 100 gives 0110; 101 gives 1000 if funct7b5 else 0111; 110 gives 0011; 111 gives 0010.
REQ-012 instr_done SHALL be 1 exactly in MEMWB, MEMWRITE, ALUWB, BRANCH, and in DECODE when the opcode is illegal.
REQ-013 op, funct3 and funct7b5 SHALL be sampled only for next-state and output decode; the block SHALL hold no copy of the instruction.
REQ-014 All outputs SHALL be glitch-free functions of state plus the op, funct3, funct7b5 and Zero inputs; there are no output registers.

Reset
REQ-015 While reset=1 at a rising edge, the state SHALL become FETCH regardless of current state, including mid-instruction.
REQ-016 In the cycle after reset deasserts, FETCH outputs SHALL be driven (IRWrite=1, PCWrite=1) and instr_done SHALL be 0.
REQ-017 A reset asserted during MEMWRITE SHALL still present MemWrite=1 for that cycle, since outputs are combinational; the write is not suppressed.

Verification
REQ-018 Apply reset for 2 cycles, then op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; instr_done pulses in cycle 5.
REQ-019 Apply op=0110011, funct3=000, funct7b5=1 -> ALUControl=0001 in EXECUTER; with funct3=101, funct7b5=1 -> 1000; with op=0010011, funct3=000, funct7b5=1 -> 0000.
REQ-020 Apply op=1100011 with funct3=001: Zero=0 gives PCWrite=1 in BRANCH; Zero=1 gives PCWrite=0; the FSM returns to FETCH after 3 cycles in both cases.
REQ-021 Apply op=0100011 -> MemWrite=1 for exactly one cycle (cycle 4) with AdrSrc=1; RegWrite stays 0 throughout.
REQ-022 Apply op=1111111 -> returns to FETCH after DECODE; instr_done=1 in DECODE; no MemWrite, RegWrite or PCWrite in DECODE.
REQ-023 Assert reset during the EXECUTEI cycle of an addi -> next state FETCH; no ALUWB cycle occurs and RegWrite stays 0.
